// File: rtl/addsub_serial_if.sv
// rtl/addsub_serial_if.sv - operand/result handshake bundle for addsub_serial
//
// Purpose: groups the operand handshake (in_valid/in_ready, a, b, sub) and the
// result handshake (out_valid/out_ready, s, flags) of addsub_serial.
// Ports (signals):
//   in_valid, a, b, sub      operand side, driven by the source
//   in_ready                 driven by the adder
//   out_valid, s, overflow,
//   carry, neg, zero         result side, driven by the adder
//   out_ready                driven by the consumer
// Modports: slave = adder side, master = source/consumer side.
interface addsub_serial_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             overflow;
  logic             carry;
  logic             neg;
  logic             zero;

  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, s, overflow, carry, neg, zero
  );

  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, s, overflow, carry, neg, zero
  );
endinterface

// File: rtl/addsub_serial.sv
// rtl/addsub_serial.sv - digit-serial adder/subtractor with valid/ready handshakes
//
// Purpose: adds or subtracts two WIDTH-bit operands CHUNK bits per clock, LSB
// first, and reports overflow/carry/neg/zero with signed or unsigned meaning.
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   addsub_serial_if.slave: in_valid/in_ready/a/b/sub operand handshake,
//         out_valid/out_ready/s/overflow/carry/neg/zero result handshake
// Parameters: WIDTH (multiple of CHUNK), CHUNK (bits per cycle), SIGNED (flag meaning).
// Optional feature: define ADDSUB_SAT_EN to clamp s on overflow instead of wrapping.
module addsub_serial #(
  parameter int WIDTH  = 16,
  parameter int CHUNK  = 4,
  parameter int SIGNED = 1
) (
  input  logic            clk,
  input  logic            rst,
  addsub_serial_if.slave  bus
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state, state_nx;
  logic [WIDTH-1:0]  a_r, b_r, s_acc, s_r;
  logic              sub_r, c_r;
  logic [CW-1:0]     cnt;
  logic              out_valid_r, ov_r, carry_r, neg_r, zero_r;

  logic [CHUNK-1:0]  a_ch, b_ch, sum;
  logic              c_nx, last, cin_msb, ov_c, neg_c, zero_c;
  logic [WIDTH-1:0]  s_raw, s_fin;

  // One chunk of the ripple: a single CHUNK-bit adder reused every cycle.
  always_comb begin
    a_ch        = a_r[cnt*CHUNK +: CHUNK];
    b_ch        = b_r[cnt*CHUNK +: CHUNK];
    {c_nx, sum} = {1'b0, a_ch} + {1'b0, b_ch} + {{CHUNK{1'b0}}, c_r};
    last        = (cnt == CW'(NCHUNK - 1));
    s_raw       = s_acc;
    s_raw[cnt*CHUNK +: CHUNK] = sum;
    // Carry into the top bit recovered from the top-bit sum: s = a ^ b ^ cin.
    cin_msb     = sum[CHUNK-1] ^ a_ch[CHUNK-1] ^ b_ch[CHUNK-1];
    if (SIGNED != 0) ov_c = cin_msb ^ c_nx;
    else             ov_c = sub_r ? ~c_nx : c_nx;
    s_fin       = s_raw;
`ifdef ADDSUB_SAT_EN
    if (ov_c) begin
      if (SIGNED != 0)
        // Signed overflow flips the sign bit, so a set raw MSB means the true result was positive.
        s_fin = s_raw[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}} : {1'b1, {(WIDTH-1){1'b0}}};
      else
        s_fin = sub_r ? '0 : '1;
    end
    // A clamped unsigned result is never below zero.
    if (SIGNED != 0) neg_c = s_fin[WIDTH-1];
    else             neg_c = sub_r & ~c_nx & ~ov_c;
`else
    if (SIGNED != 0) neg_c = s_fin[WIDTH-1];
    else             neg_c = sub_r & ~c_nx;
`endif
    zero_c      = (s_fin == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.in_valid)  state_nx = RUN;
      RUN:     if (last)          state_nx = DONE;
      DONE:    if (bus.out_ready) state_nx = IDLE;
      default:                    state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_r         <= '0;
      b_r         <= '0;
      s_acc       <= '0;
      s_r         <= '0;
      sub_r       <= 1'b0;
      c_r         <= 1'b0;
      cnt         <= '0;
      out_valid_r <= 1'b0;
      ov_r        <= 1'b0;
      carry_r     <= 1'b0;
      neg_r       <= 1'b0;
      zero_r      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          a_r   <= bus.a;
          // Subtraction as A + ~B + 1: invert B here, the +1 enters as carry-in.
          b_r   <= bus.b ^ {WIDTH{bus.sub}};
          sub_r <= bus.sub;
          c_r   <= bus.sub;
          cnt   <= '0;
          s_acc <= '0;
        end
        RUN: begin
          s_acc <= s_raw;
          c_r   <= c_nx;
          cnt   <= cnt + CW'(1);
          if (last) begin
            cnt         <= '0;
            s_r         <= s_fin;
            ov_r        <= ov_c;
            carry_r     <= c_nx;
            neg_r       <= neg_c;
            zero_r      <= zero_c;
            out_valid_r <= 1'b1;
          end
        end
        DONE: if (bus.out_ready) out_valid_r <= 1'b0;
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE) && !rst;
  assign bus.out_valid = out_valid_r;
  assign bus.s         = s_r;
  assign bus.overflow  = ov_r;
  assign bus.carry     = carry_r;
  assign bus.neg       = neg_r;
  assign bus.zero      = zero_r;
endmodule
